// File: rtl/johnson_pkg.sv
// Shared types and constants for the Johnson-code receive path.
// Holds the lock FSM states, the legal code set and the step classifier.
package johnson_pkg;

    typedef enum logic [1:0] {
        ACQ,
        TRACK,
        LOCKED
    } state_e;

    typedef enum logic [1:0] {
        HOLD,
        FWD,
        BWD,
        SKIP
    } step_e;

    localparam logic [3:0] CODE_0 = 4'b0000;
    localparam logic [3:0] CODE_1 = 4'b1000;
    localparam logic [3:0] CODE_2 = 4'b1100;
    localparam logic [3:0] CODE_3 = 4'b1110;
    localparam logic [3:0] CODE_4 = 4'b1111;
    localparam logic [3:0] CODE_5 = 4'b0111;
    localparam logic [3:0] CODE_6 = 4'b0011;
    localparam logic [3:0] CODE_7 = 4'b0001;

    // Modulo-8 distance between indices; the 3-bit subtraction wraps 7->0 naturally.
    function automatic step_e classify_step(input logic [2:0] ref_idx,
                                            input logic [2:0] new_idx);
        logic [2:0] diff;
        diff = new_idx - ref_idx;
        case (diff)
            3'd0:    return HOLD;
            3'd1:    return FWD;
            3'd7:    return BWD;
            default: return SKIP;
        endcase
    endfunction

endpackage

// File: rtl/johnson_code_lut.sv
// Combinational map from a 4-bit Johnson sample to {legal, index}.
// Illegal codes report index 0 with legal low.
module johnson_code_lut
    import johnson_pkg::*;
(
    input  logic [3:0] code_i,
    output logic       legal_o,
    output logic [2:0] idx_o
);

    always_comb begin
        legal_o = 1'b1;
        idx_o   = 3'd0;
        case (code_i)
            CODE_0:  idx_o = 3'd0;
            CODE_1:  idx_o = 3'd1;
            CODE_2:  idx_o = 3'd2;
            CODE_3:  idx_o = 3'd3;
            CODE_4:  idx_o = 3'd4;
            CODE_5:  idx_o = 3'd5;
            CODE_6:  idx_o = 3'd6;
            CODE_7:  idx_o = 3'd7;
            default: legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/johnson_decoder.sv
// Johnson-code receiver: decodes position, classifies each step, flags errors
// and declares lock after LOCK_CNT consecutive same-direction steps.
module johnson_decoder
    import johnson_pkg::*;
#(
    parameter int LOCK_CNT = 3,
    parameter int ERR_W    = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [3:0]       in_code_i,
    input  logic             in_valid_i,
    output logic [2:0]       out_idx_o,
    output logic             out_valid_o,
    output logic             step_fwd_o,
    output logic             step_bwd_o,
    output logic             err_o,
    output logic             locked_o,
    output logic [ERR_W-1:0] err_cnt_o
);

    localparam logic [3:0]       LOCK_TARGET = 4'(LOCK_CNT);
    localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};

    state_e           state_q, state_d;
    logic [2:0]       ref_q, ref_d;
    logic [3:0]       streak_q, streak_d;
    logic             dir_bwd_q, dir_bwd_d;
    logic [2:0]       idx_q, idx_d;
    logic             valid_q, valid_d;
    logic             fwd_q, fwd_d;
    logic             bwd_q, bwd_d;
    logic             err_q, err_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    logic             lut_legal;
    logic [2:0]       lut_idx;
    step_e            step;
    logic             is_bwd;

    johnson_code_lut u_lut (
        .code_i  (in_code_i),
        .legal_o (lut_legal),
        .idx_o   (lut_idx)
    );

    // The reference is valid exactly when the FSM is outside ACQ.
    always_comb begin
        state_d   = state_q;
        ref_d     = ref_q;
        streak_d  = streak_q;
        dir_bwd_d = dir_bwd_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        fwd_d     = 1'b0;
        bwd_d     = 1'b0;
        err_d     = 1'b0;
        err_cnt_d = err_cnt_q;
        step      = classify_step(ref_q, lut_idx);
        is_bwd    = (step == BWD);

        if (in_valid_i) begin
            if (!lut_legal) begin
                err_d    = 1'b1;
                ref_d    = 3'd0;
                streak_d = 4'd0;
                valid_d  = 1'b0;
                state_d  = ACQ;
            end else if (state_q == ACQ) begin
                ref_d    = lut_idx;
                idx_d    = lut_idx;
                valid_d  = 1'b1;
                streak_d = 4'd0;
                state_d  = TRACK;
            end else begin
                case (step)
                    HOLD: ;
                    FWD, BWD: begin
                        fwd_d = !is_bwd;
                        bwd_d = is_bwd;
                        ref_d = lut_idx;
                        idx_d = lut_idx;
                        if (is_bwd == dir_bwd_q) begin
                            streak_d = (streak_q >= LOCK_TARGET) ? LOCK_TARGET
                                                                 : streak_q + 4'd1;
                            if (state_q == TRACK && streak_d == LOCK_TARGET) begin
                                state_d = LOCKED;
                            end
                        end else begin
                            streak_d  = 4'd1;
                            dir_bwd_d = is_bwd;
                            if (state_q == LOCKED) begin
                                state_d = TRACK;
                            end else if (streak_d == LOCK_TARGET) begin
                                state_d = LOCKED;
                            end
                        end
                    end
                    default: begin
                        err_d    = 1'b1;
                        ref_d    = lut_idx;
                        idx_d    = lut_idx;
                        valid_d  = 1'b1;
                        streak_d = 4'd0;
                        state_d  = TRACK;
                    end
                endcase
            end
        end

        if (err_d && err_cnt_q != ERR_MAX) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ACQ;
            ref_q     <= 3'd0;
            streak_q  <= 4'd0;
            dir_bwd_q <= 1'b0;
            idx_q     <= 3'd0;
            valid_q   <= 1'b0;
            fwd_q     <= 1'b0;
            bwd_q     <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            ref_q     <= ref_d;
            streak_q  <= streak_d;
            dir_bwd_q <= dir_bwd_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            fwd_q     <= fwd_d;
            bwd_q     <= bwd_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign out_idx_o   = idx_q;
    assign out_valid_o = valid_q;
    assign step_fwd_o  = fwd_q;
    assign step_bwd_o  = bwd_q;
    assign err_o       = err_q;
    assign locked_o    = (state_q == LOCKED);
    assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_johnson_decoder.sv
// Directed testbench for johnson_decoder with LOCK_CNT=3, ERR_W=8.
// Status vector layout: {idx[2:0], valid, fwd, bwd, err, locked}.
module tb_johnson_decoder;

    logic       clk;
    logic       rst_ni;
    logic [3:0] in_code;
    logic       in_valid;
    logic [2:0] out_idx;
    logic       out_valid;
    logic       step_fwd;
    logic       step_bwd;
    logic       err;
    logic       locked;
    logic [7:0] err_cnt;
    logic [7:0] status;

    int checks = 0;
    int errors = 0;

    johnson_decoder #(.LOCK_CNT(3), .ERR_W(8)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .in_code_i   (in_code),
        .in_valid_i  (in_valid),
        .out_idx_o   (out_idx),
        .out_valid_o (out_valid),
        .step_fwd_o  (step_fwd),
        .step_bwd_o  (step_bwd),
        .err_o       (err),
        .locked_o    (locked),
        .err_cnt_o   (err_cnt)
    );

    assign status = {out_idx, out_valid, step_fwd, step_bwd, err, locked};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [3:0] code);
        @(negedge clk);
        in_code  = code;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni   = 1'b1;
        in_code  = 4'b0000;
        in_valid = 1'b0;
        #1 rst_ni = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (status !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_status: got %b expected %b", status, 8'h00);
        end
        checks++;
        if (err_cnt !== 8'd0) begin
            errors++;
            $display("[TB] FAIL reset_err_cnt: got %0d expected 0", err_cnt);
        end
        @(negedge clk);
        rst_ni = 1'b1;
    endtask

    task automatic test_lock_forward();
        logic [3:0] codes [4] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110};
        logic [7:0] exp   [4] = '{8'b000_1_0000, 8'b001_1_1000,
                                  8'b010_1_1000, 8'b011_1_1001};
        for (int i = 0; i < 4; i++) begin
            drive(codes[i]);
            checks++;
            if (status !== exp[i]) begin
                errors++;
                $display("[TB] FAIL lock_fwd[%0d]: got %b expected %b", i, status, exp[i]);
            end
        end
    endtask

    task automatic test_wrap();
        logic [3:0] codes [5] = '{4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000};
        logic [7:0] exp   [5] = '{8'b100_1_1001, 8'b101_1_1001, 8'b110_1_1001,
                                  8'b111_1_1001, 8'b000_1_1001};
        for (int i = 0; i < 5; i++) begin
            drive(codes[i]);
            checks++;
            if (status !== exp[i]) begin
                errors++;
                $display("[TB] FAIL wrap[%0d]: got %b expected %b", i, status, exp[i]);
            end
        end
        checks++;
        if (err_cnt !== 8'd0) begin
            errors++;
            $display("[TB] FAIL wrap_err_cnt: got %0d expected 0", err_cnt);
        end
    endtask

    task automatic test_illegal();
        drive(4'b1010);
        checks++;
        if (status !== 8'b000_0_0010) begin
            errors++;
            $display("[TB] FAIL illegal_status: got %b expected %b", status, 8'b000_0_0010);
        end
        checks++;
        if (err_cnt !== 8'd1) begin
            errors++;
            $display("[TB] FAIL illegal_err_cnt: got %0d expected 1", err_cnt);
        end
        drive(4'b0011);
        checks++;
        if (status !== 8'b110_1_0000) begin
            errors++;
            $display("[TB] FAIL reacquire: got %b expected %b", status, 8'b110_1_0000);
        end
    endtask

    task automatic test_skip();
        logic [3:0] codes [5] = '{4'b0001, 4'b0000, 4'b1000, 4'b1100, 4'b1111};
        logic [7:0] exp   [5] = '{8'b111_1_1000, 8'b000_1_1000, 8'b001_1_1001,
                                  8'b010_1_1001, 8'b100_1_0010};
        for (int i = 0; i < 5; i++) begin
            drive(codes[i]);
            checks++;
            if (status !== exp[i]) begin
                errors++;
                $display("[TB] FAIL skip[%0d]: got %b expected %b", i, status, exp[i]);
            end
        end
        checks++;
        if (err_cnt !== 8'd2) begin
            errors++;
            $display("[TB] FAIL skip_err_cnt: got %0d expected 2", err_cnt);
        end
    endtask

    // 1111 -> 1110 is the first backward step; later entries cover relock, 0->7 wrap and hold.
    task automatic test_direction_change();
        logic [3:0] codes [14] = '{4'b0111, 4'b0011, 4'b0001, 4'b0000, 4'b1000,
                                   4'b1100, 4'b1110, 4'b1111, 4'b1110, 4'b1100,
                                   4'b1000, 4'b0000, 4'b0001, 4'b0001};
        logic [7:0] exp   [14] = '{8'b101_1_1000, 8'b110_1_1000, 8'b111_1_1001,
                                   8'b000_1_1001, 8'b001_1_1001, 8'b010_1_1001,
                                   8'b011_1_1001, 8'b100_1_1001, 8'b011_1_0100,
                                   8'b010_1_0100, 8'b001_1_0101, 8'b000_1_0101,
                                   8'b111_1_0101, 8'b111_1_0001};
        for (int i = 0; i < 14; i++) begin
            drive(codes[i]);
            checks++;
            if (status !== exp[i]) begin
                errors++;
                $display("[TB] FAIL dir[%0d]: got %b expected %b", i, status, exp[i]);
            end
        end
    endtask

    task automatic test_valid_low();
        @(negedge clk);
        in_code  = 4'b1010;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (status !== 8'b111_1_0001) begin
            errors++;
            $display("[TB] FAIL valid_low_status: got %b expected %b", status, 8'b111_1_0001);
        end
        checks++;
        if (err_cnt !== 8'd2) begin
            errors++;
            $display("[TB] FAIL valid_low_err_cnt: got %0d expected 2", err_cnt);
        end
    endtask

    task automatic test_saturation_and_reset();
        @(negedge clk);
        in_code  = 4'b1010;
        in_valid = 1'b1;
        repeat (252) @(posedge clk);
        #1;
        checks++;
        if (err_cnt !== 8'd254) begin
            errors++;
            $display("[TB] FAIL sat_pre: got %0d expected 254", err_cnt);
        end
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if (err_cnt !== 8'd255) begin
            errors++;
            $display("[TB] FAIL sat_hold: got %0d expected 255", err_cnt);
        end
        checks++;
        if (status !== 8'b111_0_0010) begin
            errors++;
            $display("[TB] FAIL sat_status: got %b expected %b", status, 8'b111_0_0010);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (status !== 8'b111_0_0000 || err_cnt !== 8'd255) begin
            errors++;
            $display("[TB] FAIL sat_idle: got %b/%0d expected %b/255", status, err_cnt, 8'b111_0_0000);
        end
        @(negedge clk);
        in_valid = 1'b1;
        @(posedge clk);
        #2;
        rst_ni = 1'b0;
        #1;
        checks++;
        if (status !== 8'h00 || err_cnt !== 8'd0) begin
            errors++;
            $display("[TB] FAIL async_reset: got %b/%0d expected %b/0", status, err_cnt, 8'h00);
        end
        in_valid = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1;
        drive(4'b1000);
        checks++;
        if (status !== 8'b001_1_0000 || err_cnt !== 8'd0) begin
            errors++;
            $display("[TB] FAIL post_reset_acq: got %b/%0d expected %b/0", status, err_cnt, 8'b001_1_0000);
        end
    endtask

    initial begin
        test_reset();
        test_lock_forward();
        test_wrap();
        test_illegal();
        test_skip();
        test_direction_change();
        test_valid_low();
        test_saturation_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
